bcd_7seg_scan: RTL
==================

// Module: bcd_7seg_scan
// PURPOSE
//  Consumes the packed BCD count from the decimal counter stage and drives a
//  time-multiplexed common-segment 7-segment display, one digit per scan slot.
//  Input is snapshotted once per frame, so a count change never tears a frame.
//  Adds anti-ghost blanking, leading-zero suppression and a dash for invalid nibbles.
// PARAMETERS
//  NUM_DIGITS    2      number of BCD digits / display positions (>=1)
//  SCAN_DIV      50000  clock cycles per digit slot (>=2)
//  BLANK_CYCLES  16     cycles at slot start with all digits off (1..SCAN_DIV-1)
//  ACTIVE_LOW    1      1: SEG and DIG are driven active-low; 0: active-high
// PORTS
//  CLK     in   1             single clock; all logic on posedge CLK
//  RESET   in   1             synchronous reset, active-high
//  BCD     in   4*NUM_DIGITS  packed BCD; [3:0] = digit 0 (least significant)
//  SEG     out  7             segments {g,f,e,d,c,b,a}; bit0 = a
//  DIG     out  NUM_DIGITS    one-hot digit enable; bit i = digit i
//  FRAME   out  1             1-cycle pulse on the edge BCD is snapshotted
// BEHAVIOUR
//  - Reset (RESET=1 at posedge): cnt=0, idx=0, snapshot=0, FRAME=0,
//    SEG=all segments off, DIG=all off (polarity per ACTIVE_LOW). Mid-frame
//    reset aborts the frame; the first frame after reset shows snapshot 0.
//  - cnt counts 0..SCAN_DIV-1, then wraps to 0. One slot = SCAN_DIV cycles.
//  - Edge where cnt wraps to 0: idx<=idx+1 (NUM_DIGITS-1 wraps to 0); DIG<=off;
//    SEG<=decode of the digit for the new idx.
//  - Frame wrap (cnt wraps and idx==NUM_DIGITS-1): snapshot<=BCD, FRAME<=1 for
//    that cycle only; SEG for digit 0 decodes from the incoming BCD directly.
//  - Edge where cnt becomes BLANK_CYCLES: DIG<=one-hot(idx). DIG is off for
//    exactly BLANK_CYCLES cycles per slot; SEG is stable for the whole slot.
//  - Decode: 0-9 standard patterns (active-high 3F,06,5B,4F,66,6D,7D,07,7F,6F);
//    nibble A-F -> dash (segment g only, 0x40).
//  - Leading-zero blanking: digit i>0 shows SEG all-off when it and all
//    higher snapshot digits equal 0. Digit 0 is never blanked. An invalid
//    nibble counts as nonzero. DIG timing is unaffected by blanking.
//  - Latency: a BCD change becomes visible at the next frame wrap (at most
//    NUM_DIGITS*SCAN_DIV cycles). All outputs are registered; no comb paths.
//  - ACTIVE_LOW inverts SEG and DIG at the output register only.
// STRUCTURE
//  - Shared package: 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
//    function clog2 for cnt/idx widths.
//  - One sub-module: bcd_to_seg7 (combinational nibble -> 7-bit pattern,
//    active-high). Scan counter, snapshot, blanking and output regs stay here.
// TESTING (NUM_DIGITS=2, SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
//  1 RESET=1 for 3 cycles mid-slot -> SEG=7'h7F, DIG=2'b11, FRAME=0; restart.
//  2 BCD=8'h42 held -> after FRAME: slot0 cycles 2-7 DIG=2'b10 SEG=7'h24;
//    slot1 DIG=2'b01 SEG=7'h19; DIG=2'b11 at cnt 0-1.
//  3 BCD=8'h07 -> slot1 SEG=7'h7F (blanked); BCD=8'h00 -> slot0 SEG=7'h40.
//  4 BCD=8'h2E -> slot0 SEG=7'h3F (dash), slot1 SEG=7'h24.
//  5 BCD 8'h19->8'h20 during slot0 -> slot1 still shows 1 (7'h79); next frame
//    shows slot0 7'h40, slot1 7'h24.
//  6 Free run 64 cycles -> FRAME exactly every 16 cycles, 1 cycle wide; DIG
//    never has two bits asserted.

Source files
------------

// File: rtl/bcd_7seg_scan_pkg.sv
// Shared definitions for the multiplexed BCD 7-segment scanner:
// active-high segment patterns and a width helper.
package bcd_7seg_scan_pkg;

  // Segment order {g,f,e,d,c,b,a}, bit0 = a, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Ceiling log2, never below 1 so a counter/index always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_7seg_scan_bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern.
// Non-decimal nibbles (A-F) render as a dash.
module bcd_to_seg7
  import bcd_7seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 7-segment driver for a packed BCD count, with per-frame
// snapshot, anti-ghost blanking at slot start and leading-zero suppression.
module bcd_7seg_scan
  import bcd_7seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] BCD,
  output logic [6:0]              SEG,
  output logic [NUM_DIGITS-1:0]   DIG,
  output logic                    FRAME
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snapshot;

  logic                  last_cnt;
  logic                  last_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_run;
  logic [3:0]            snap_nib;
  logic                  snap_blank;
  logic [3:0]            next_nib;
  logic                  next_blank;
  logic [6:0]            next_pat;
  logic [NUM_DIGITS-1:0] dig_hot;

  assign last_cnt = (cnt == CNT_LAST);
  assign last_idx = (idx == IDX_LAST);
  assign next_idx = last_idx ? '0 : idx + IDX_W'(1);

  // lz[i]: digit i and every higher snapshot digit are zero; digit 0 never blanks
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run & (snapshot[4*i +: 4] == 4'd0);
      lz[i]  = lz_run;
    end
  end

  always_comb begin
    snap_nib   = '0;
    snap_blank = 1'b0;
    dig_hot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (next_idx == IDX_W'(i)) begin
        snap_nib   = snapshot[4*i +: 4];
        snap_blank = lz[i];
      end
      if (idx == IDX_W'(i)) dig_hot[i] = 1'b1;
    end
  end

  // At a frame wrap the snapshot is being reloaded, so digit 0 comes from BCD itself
  assign next_nib   = last_idx ? BCD[3:0] : snap_nib;
  assign next_blank = ~last_idx & snap_blank;

  bcd_to_seg7 u_dec (
    .nib (next_nib),
    .seg (next_pat)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      idx      <= '0;
      snapshot <= '0;
      FRAME    <= 1'b0;
      SEG      <= SEG_IDLE;
      DIG      <= DIG_IDLE;
    end else begin
      FRAME <= 1'b0;
      if (last_cnt) begin
        cnt <= '0;
        idx <= next_idx;
        DIG <= DIG_IDLE;
        if (next_blank) SEG <= SEG_IDLE;
        else            SEG <= ACTIVE_LOW ? ~next_pat : next_pat;
        if (last_idx) begin
          snapshot <= BCD;
          FRAME    <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_BLANK) DIG <= ACTIVE_LOW ? ~dig_hot : dig_hot;
      end
    end
  end

endmodule
